// File: rtl/lsu_bus_master.sv
// Load/store initiator for the core data bus: one request at a time, fixed wait
// window, byte/halfword extension on loads, misaligned requests rejected without bus traffic.
module lsu_bus_master #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        bus_rw,
  output logic [1:0]  bus_len,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_write,
  input  logic [31:0] bus_read
);

  // state  | meaning
  // IDLE   | ready for a request
  // ACCESS | request driven on the bus, wait counter running
  // DONE   | good response strobe
  // ERR    | misaligned / reserved-size response strobe
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic        rw_q;
  logic        unsigned_q;
  logic        misaligned;
  logic        accept;
  logic        cnt_zero;
  logic [31:0] load_ext;

  always_comb begin
    misaligned = 1'b0;
    unique case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  assign accept   = (state == IDLE) && req_valid;
  assign cnt_zero = (cnt == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // bus_rw is decoded from state so an async reset drops it immediately
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    bus_rw     = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = misaligned ? ERR : ACCESS;
        end
      end
      ACCESS: begin
        bus_rw = rw_q;
        if (cnt_zero) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_ext = bus_read;
    unique case (bus_len)
      2'b00:   load_ext = {{24{bus_read[7]  & ~unsigned_q}}, bus_read[7:0]};
      2'b01:   load_ext = {{16{bus_read[15] & ~unsigned_q}}, bus_read[15:0]};
      default: load_ext = bus_read;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_addr   <= 32'h0;
      bus_len    <= 2'b00;
      bus_write  <= 32'h0;
      rw_q       <= 1'b0;
      unsigned_q <= 1'b0;
      cnt        <= 4'd0;
      resp_rdata <= 32'h0;
    end else begin
      if (accept) begin
        if (misaligned) begin
          resp_rdata <= 32'h0;
        end else begin
          bus_addr   <= req_addr;
          bus_len    <= req_size;
          rw_q       <= req_store;
          unsigned_q <= req_unsigned;
          cnt        <= CNT_INIT;
          if (req_store) begin
            bus_write <= req_wdata;
          end
        end
      end
      if (state == ACCESS) begin
        if (cnt_zero) begin
          resp_rdata <= rw_q ? 32'h0 : load_ext;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: vector table, hand-written corner
// sequences and randomized requests against a behavioural model, on WAIT_CYCLES=1 and 3.
module tb_lsu_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1_n, rst3_n;
  logic        v1, v3;
  logic        st;
  logic [1:0]  sz;
  logic        un;
  logic [31:0] ad, wd, rd_val;
  logic        rd_mode;
  logic [31:0] rd1, rd3;

  logic        r1, rv1, re1, brw1;
  logic [31:0] rdat1, badr1, bwr1;
  logic [1:0]  blen1;
  logic        r3, rv3, re3, brw3;
  logic [31:0] rdat3, badr3, bwr3;
  logic [1:0]  blen3;

  // responder: either a fixed word or an address-derived word
  assign rd1 = rd_mode ? (badr1 * 32'd3 + 32'd1) : rd_val;
  assign rd3 = rd_val;

  lsu_bus_master #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .req_valid(v1), .req_ready(r1), .req_store(st),
    .req_size(sz), .req_unsigned(un), .req_addr(ad), .req_wdata(wd),
    .resp_valid(rv1), .resp_err(re1), .resp_rdata(rdat1), .bus_rw(brw1),
    .bus_len(blen1), .bus_addr(badr1), .bus_write(bwr1), .bus_read(rd1));

  lsu_bus_master #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .req_valid(v3), .req_ready(r3), .req_store(st),
    .req_size(sz), .req_unsigned(un), .req_addr(ad), .req_wdata(wd),
    .resp_valid(rv3), .resp_err(re3), .resp_rdata(rdat3), .bus_rw(brw3),
    .bus_len(blen3), .bus_addr(badr3), .bus_write(bwr3), .bus_read(rd3));

  int sel;
  logic        o_ready, o_rv, o_re, o_rw;
  logic [31:0] o_rdat, o_addr, o_write;
  logic [1:0]  o_len;

  always_comb begin
    if (sel == 1) begin
      o_ready = r3; o_rv = rv3; o_re = re3; o_rw = brw3;
      o_rdat = rdat3; o_addr = badr3; o_write = bwr3; o_len = blen3;
    end else begin
      o_ready = r1; o_rv = rv1; o_re = re1; o_rw = brw1;
      o_rdat = rdat1; o_addr = badr1; o_write = bwr1; o_len = blen1;
    end
  end

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] m_addr[2];
  logic [1:0]  m_len[2];
  logic [31:0] m_write[2];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) $display("FAIL %s (dut W=%0d): got %h, expected %h", nm, (sel == 1) ? 3 : 1, got, want);
    else n_pass++;
  endtask

  function automatic logic [31:0] model_ext(input logic [31:0] r, input logic [1:0] s, input logic u);
    int unsigned b, h;
    b = r % 256;
    h = r % 65536;
    if (s == 2'd0) return (u || b < 128) ? b : b - 256;
    if (s == 2'd1) return (u || h < 32768) ? h : h - 65536;
    return r;
  endfunction

  function automatic logic model_err(input logic [1:0] s, input logic [31:0] a);
    if (s == 2'd3) return 1'b1;
    return (a % (32'd1 << s)) != 0;
  endfunction

  // Entered and left one delta-safe #1 after a rising edge with the DUT idle.
  task automatic txn(input logic t_st, input logic [1:0] t_sz, input logic t_un,
                     input logic [31:0] t_ad, input logic [31:0] t_wd, input logic [31:0] t_rd,
                     input logic t_err, input logic [31:0] t_want);
    int w;
    w = (sel == 1) ? 3 : 1;
    chk("ready_before_req", 32'(o_ready), 32'd1);
    st = t_st; sz = t_sz; un = t_un; ad = t_ad; wd = t_wd; rd_val = t_rd;
    if (sel == 1) v3 = 1'b1; else v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0; v3 = 1'b0;
    // request inputs must be ignored once accepted
    ad = ~t_ad; wd = ~t_wd; sz = ~t_sz; st = ~t_st; un = ~t_un;
    if (t_err) begin
      chk("err_resp_valid", 32'(o_rv), 32'd1);
      chk("err_resp_err", 32'(o_re), 32'd1);
      chk("err_resp_rdata", o_rdat, 32'd0);
      chk("err_bus_rw", 32'(o_rw), 32'd0);
      chk("err_bus_addr_kept", o_addr, m_addr[sel]);
      chk("err_bus_len_kept", 32'(o_len), 32'(m_len[sel]));
      chk("err_ready_low", 32'(o_ready), 32'd0);
    end else begin
      m_addr[sel] = t_ad;
      m_len[sel]  = t_sz;
      if (t_st) m_write[sel] = t_wd;
      for (int k = 0; k < w; k++) begin
        chk("access_bus_rw", 32'(o_rw), 32'(t_st));
        chk("access_bus_addr", o_addr, m_addr[sel]);
        chk("access_bus_len", 32'(o_len), 32'(m_len[sel]));
        chk("access_bus_write", o_write, m_write[sel]);
        chk("access_resp_valid", 32'(o_rv), 32'd0);
        chk("access_ready", 32'(o_ready), 32'd0);
        @(posedge clk); #1;
      end
      chk("done_resp_valid", 32'(o_rv), 32'd1);
      chk("done_resp_err", 32'(o_re), 32'd0);
      chk("done_resp_rdata", o_rdat, t_want);
      chk("done_bus_rw", 32'(o_rw), 32'd0);
      chk("done_ready", 32'(o_ready), 32'd0);
    end
    @(posedge clk); #1;
    chk("after_resp_valid", 32'(o_rv), 32'd0);
    chk("after_ready", 32'(o_ready), 32'd1);
    chk("after_rdata_held", o_rdat, t_want);
    chk("after_bus_addr_held", o_addr, m_addr[sel]);
  endtask

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    logic [31:0] want;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] addrs[3];
    int acc[3];
    int nacc, nresp, cyc;
    logic acc_now;
    logic r_st, r_un, r_err;
    logic [1:0] r_sz;
    logic [31:0] r_ad, r_wd, r_rd, r_want;

    tbl[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,          32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
    tbl[1]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0,          32'h0000_0080, 1'b0, 32'hFFFF_FF80};
    tbl[2]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0003, 32'h0,          32'h0000_0080, 1'b0, 32'h0000_0080};
    tbl[3]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0,          32'h0000_8001, 1'b0, 32'hFFFF_8001};
    tbl[4]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0,          32'hFFFF_8001, 1'b0, 32'h0000_8001};
    tbl[5]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,          32'h1234_567F, 1'b0, 32'h0000_007F};
    tbl[6]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'h1234_5678,  32'hFFFF_FFFF, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 2'b10, 1'b1, 32'h0000_0104, 32'h0,          32'h8000_0001, 1'b0, 32'h8000_0001};
    tbl[8]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0,          32'h5555_5555, 1'b1, 32'h0};
    tbl[9]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0,          32'h5555_5555, 1'b1, 32'h0};
    tbl[10] = '{1'b1, 2'b11, 1'b0, 32'h0000_0000, 32'hAAAA_AAAA,  32'h5555_5555, 1'b1, 32'h0};

    rst1_n = 1'b0; rst3_n = 1'b0; v1 = 1'b0; v3 = 1'b0;
    st = 1'b0; sz = 2'b00; un = 1'b0; ad = 32'h0; wd = 32'h0; rd_val = 32'h0; rd_mode = 1'b0;
    sel = 0;
    for (int s = 0; s < 2; s++) begin
      m_addr[s] = 32'h0; m_len[s] = 2'b00; m_write[s] = 32'h0;
    end
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = s; #1;
      chk("rst_req_ready", 32'(o_ready), 32'd1);
      chk("rst_resp_valid", 32'(o_rv), 32'd0);
      chk("rst_resp_err", 32'(o_re), 32'd0);
      chk("rst_resp_rdata", o_rdat, 32'd0);
      chk("rst_bus_rw", 32'(o_rw), 32'd0);
      chk("rst_bus_len", 32'(o_len), 32'd0);
      chk("rst_bus_addr", o_addr, 32'd0);
      chk("rst_bus_write", o_write, 32'd0);
    end
    @(negedge clk); rst1_n = 1'b1; rst3_n = 1'b1;
    @(posedge clk); #1;

    // vector table on the single-wait instance
    sel = 0; #1;
    for (int i = 0; i < 11; i++)
      txn(tbl[i].st, tbl[i].sz, tbl[i].un, tbl[i].ad, tbl[i].wd, tbl[i].rd, tbl[i].err, tbl[i].want);

    // three-wait instance: word store held for exactly 3 cycles, then errors
    sel = 1; #1;
    txn(1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 32'h0);
    txn(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0, 32'h0, 1'b1, 32'h0);
    txn(1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0, 32'h0000_00C3, 1'b0, 32'hFFFF_FFC3);

    // reset in the second ACCESS cycle of a store
    st = 1'b1; sz = 2'b10; un = 1'b0; ad = 32'h0000_0300; wd = 32'hCAFE_F00D;
    v3 = 1'b1;
    @(posedge clk); #1; v3 = 1'b0;
    chk("midrst_rw_cycle1", 32'(o_rw), 32'd1);
    @(posedge clk); #1;
    chk("midrst_rw_cycle2", 32'(o_rw), 32'd1);
    rst3_n = 1'b0; #1;
    chk("midrst_rw_async", 32'(o_rw), 32'd0);
    chk("midrst_resp_valid", 32'(o_rv), 32'd0);
    chk("midrst_bus_addr", o_addr, 32'd0);
    m_addr[1] = 32'h0; m_len[1] = 2'b00; m_write[1] = 32'h0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("midrst_hold_resp_valid", 32'(o_rv), 32'd0);
    end
    @(negedge clk); rst3_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("postrst_resp_valid", 32'(o_rv), 32'd0);
      chk("postrst_ready", 32'(o_ready), 32'd1);
    end

    // back-to-back word loads with req_valid held high
    sel = 0; rd_mode = 1'b1; #1;
    addrs[0] = 32'h0000_0010; addrs[1] = 32'h0000_0020; addrs[2] = 32'h0000_0030;
    for (int i = 0; i < 3; i++) acc[i] = 0;
    nacc = 0; nresp = 0; cyc = 0;
    st = 1'b0; sz = 2'b10; un = 1'b0; ad = addrs[0];
    v1 = 1'b1;
    while (cyc < 60 && nresp < 3) begin
      acc_now = o_ready && v1;
      if (o_rv) begin
        chk("b2b_resp_rdata", o_rdat, addrs[nresp] * 32'd3 + 32'd1);
        chk("b2b_ready_low_in_done", 32'(o_ready), 32'd0);
        nresp++;
      end
      if (acc_now) acc[nacc] = cyc;
      @(posedge clk); #1; cyc++;
      if (acc_now) begin
        nacc++;
        if (nacc < 3) ad = addrs[nacc];
        else v1 = 1'b0;
      end
    end
    v1 = 1'b0;
    chk("b2b_accept_count", 32'(nacc), 32'd3);
    chk("b2b_resp_count", 32'(nresp), 32'd3);
    chk("b2b_spacing_1", 32'(acc[1] - acc[0]), 32'd3);
    chk("b2b_spacing_2", 32'(acc[2] - acc[1]), 32'd3);
    rd_mode = 1'b0;
    m_addr[0] = addrs[2]; m_len[0] = 2'b10;
    @(posedge clk); #1;

    // randomized requests on both instances against the model
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 1)); #1;
      r_st = 1'($urandom);
      r_sz = 2'($urandom);
      r_un = 1'($urandom);
      r_ad = $urandom;
      r_wd = $urandom;
      r_rd = $urandom;
      r_err  = model_err(r_sz, r_ad);
      r_want = (r_err || r_st) ? 32'h0 : model_ext(r_rd, r_sz, r_un);
      txn(r_st, r_sz, r_un, r_ad, r_wd, r_rd, r_err, r_want);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
